// File: rtl/countdown_controller_if.sv
// Button/tick inputs and display/alarm outputs of the countdown controller.
interface countdown_controller_if;
    logic       tick;
    logic       start_stop;
    logic       clear;
    logic       inc_min;
    logic       inc_sec;
    logic [6:0] minutes;
    logic [5:0] seconds;
    logic [1:0] state;
    logic       alarm;
    logic       div_restart;

    modport master (
        output tick, start_stop, clear, inc_min, inc_sec,
        input  minutes, seconds, state, alarm, div_restart
    );

    modport slave (
        input  tick, start_stop, clear, inc_min, inc_sec,
        output minutes, seconds, state, alarm, div_restart
    );
endinterface

// File: rtl/countdown_controller.sv
// Egg-timer countdown sequencer: setpoint entry, tick-driven countdown,
// timed alarm, and divider restart strobe.
// Optional macro COUNTDOWN_RELOAD_EN: keeps a preset captured at start and
// reloads it when the alarm ends.
module countdown_controller #(
    parameter int TICKS_PER_SEC = 2,
    parameter int MAX_MIN       = 99,
    parameter int ALARM_SECS    = 10,
    parameter int SUB_W         = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    countdown_controller_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        ALARM = 2'b11
    } state_t;

    localparam logic [SUB_W-1:0] SUB_LAST   = SUB_W'(TICKS_PER_SEC - 1);
    localparam logic [SUB_W-1:0] ALARM_LAST = SUB_W'(ALARM_SECS - 1);
    localparam logic [6:0]       MIN_LAST   = 7'(MAX_MIN);

    state_t           state_q, state_d;
    logic [6:0]       min_q, min_d;
    logic [5:0]       sec_q, sec_d;
    logic [SUB_W-1:0] sub_q, sub_d;
    logic [SUB_W-1:0] asec_q, asec_d;
    logic             alarm_q, alarm_d;
    logic             restart_q, restart_d;
    logic [6:0]       ret_min;
    logic [5:0]       ret_sec;
    logic             sec_done;
    logic             time_nz;

`ifdef COUNTDOWN_RELOAD_EN
    logic [6:0] pre_min_q, pre_min_d;
    logic [5:0] pre_sec_q, pre_sec_d;

    assign ret_min = pre_min_q;
    assign ret_sec = pre_sec_q;

    // Preset register, captured on start and cleared by clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_min_q <= '0;
            pre_sec_q <= '0;
        end else begin
            pre_min_q <= pre_min_d;
            pre_sec_q <= pre_sec_d;
        end
    end
`else
    assign ret_min = '0;
    assign ret_sec = '0;
`endif

    assign sec_done = bus.tick && (sub_q == SUB_LAST);
    assign time_nz  = (min_q != '0) || (sec_q != '0);

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            min_q     <= '0;
            sec_q     <= '0;
            sub_q     <= '0;
            asec_q    <= '0;
            alarm_q   <= 1'b0;
            restart_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            min_q     <= min_d;
            sec_q     <= sec_d;
            sub_q     <= sub_d;
            asec_q    <= asec_d;
            alarm_q   <= alarm_d;
            restart_q <= restart_d;
        end
    end

    // Next-state logic; clear overrides everything, then start_stop, then tick.
    always_comb begin
        state_d   = state_q;
        min_d     = min_q;
        sec_d     = sec_q;
        sub_d     = sub_q;
        asec_d    = asec_q;
        alarm_d   = alarm_q;
        restart_d = 1'b0;
`ifdef COUNTDOWN_RELOAD_EN
        pre_min_d = pre_min_q;
        pre_sec_d = pre_sec_q;
`endif
        if (bus.clear) begin
            state_d = IDLE;
            min_d   = '0;
            sec_d   = '0;
            sub_d   = '0;
            asec_d  = '0;
            alarm_d = 1'b0;
`ifdef COUNTDOWN_RELOAD_EN
            pre_min_d = '0;
            pre_sec_d = '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start_stop) begin
                        if (time_nz) begin
                            state_d   = RUN;
                            sub_d     = '0;
                            restart_d = 1'b1;
`ifdef COUNTDOWN_RELOAD_EN
                            pre_min_d = min_q;
                            pre_sec_d = sec_q;
`endif
                        end
                    end else begin
                        if (bus.inc_min)
                            min_d = (min_q == MIN_LAST) ? '0 : min_q + 7'd1;
                        if (bus.inc_sec)
                            sec_d = (sec_q == 6'd59) ? '0 : sec_q + 6'd1;
                    end
                end
                RUN: begin
                    if (bus.start_stop) begin
                        state_d = PAUSE;
                    end else if (sec_done) begin
                        sub_d = '0;
                        if (sec_q != '0) begin
                            sec_d = sec_q - 6'd1;
                            if (min_q == '0 && sec_q == 6'd1) begin
                                state_d = ALARM;
                                alarm_d = 1'b1;
                                asec_d  = '0;
                            end
                        end else begin
                            sec_d = 6'd59;
                            min_d = min_q - 7'd1;
                        end
                    end else if (bus.tick) begin
                        sub_d = sub_q + 1'b1;
                    end
                end
                PAUSE: begin
                    if (bus.start_stop)
                        state_d = RUN;
                end
                ALARM: begin
                    if (bus.start_stop) begin
                        state_d = IDLE;
                        alarm_d = 1'b0;
                        sub_d   = '0;
                        asec_d  = '0;
                        min_d   = ret_min;
                        sec_d   = ret_sec;
                    end else if (sec_done) begin
                        sub_d = '0;
                        if (asec_q == ALARM_LAST) begin
                            state_d = IDLE;
                            alarm_d = 1'b0;
                            asec_d  = '0;
                            min_d   = ret_min;
                            sec_d   = ret_sec;
                        end else begin
                            asec_d = asec_q + 1'b1;
                        end
                    end else if (bus.tick) begin
                        sub_d = sub_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign bus.minutes     = min_q;
    assign bus.seconds     = sec_q;
    assign bus.state       = state_q;
    assign bus.alarm       = alarm_q;
    assign bus.div_restart = restart_q;
endmodule

// File: tb/tb_countdown_controller.sv
// Self-checking bench for countdown_controller: directed table, corner
// sequences, and randomized traffic against a behavioural model.
module tb_countdown_controller;
    localparam int TPS        = 2;
    localparam int MAX_MIN    = 99;
    localparam int ALARM_SECS = 3;
`ifdef COUNTDOWN_RELOAD_EN
    localparam int RELOAD = 1;
`else
    localparam int RELOAD = 0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   tests = 0;
    int   failed = 0;

    countdown_controller_if cif ();

    countdown_controller #(
        .TICKS_PER_SEC(TPS),
        .MAX_MIN      (MAX_MIN),
        .ALARM_SECS   (ALARM_SECS),
        .SUB_W        (4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (cif.slave)
    );

    always #5 clk = ~clk;

    // Behavioural model: time kept as minutes/seconds, decremented through a
    // total-seconds count; elapsed ticks counted directly.
    int m_mode, m_min, m_sec, m_ticks, m_aticks, p_min, p_sec, m_alarm, m_restart;

    task automatic model_reset();
        m_mode = 0; m_min = 0; m_sec = 0; m_ticks = 0; m_aticks = 0;
        p_min = 0; p_sec = 0; m_alarm = 0; m_restart = 0;
    endtask

    task automatic model_idle();
        m_mode  = 0;
        m_alarm = 0;
        m_min   = RELOAD ? p_min : 0;
        m_sec   = RELOAD ? p_sec : 0;
    endtask

    task automatic model_step(input logic t, ss, cl, im, is);
        int total;
        m_restart = 0;
        if (cl) begin
            model_reset();
        end else begin
            case (m_mode)
                0: if (ss) begin
                       if (m_min != 0 || m_sec != 0) begin
                           m_mode = 1; m_ticks = 0; m_restart = 1;
                           p_min = m_min; p_sec = m_sec;
                       end
                   end else begin
                       if (im) m_min = (m_min + 1) % (MAX_MIN + 1);
                       if (is) m_sec = (m_sec + 1) % 60;
                   end
                1: if (ss) m_mode = 2;
                   else if (t) begin
                       m_ticks++;
                       if (m_ticks == TPS) begin
                           m_ticks = 0;
                           total = m_min * 60 + m_sec - 1;
                           m_min = total / 60;
                           m_sec = total % 60;
                           if (total == 0) begin
                               m_mode = 3; m_alarm = 1; m_aticks = 0;
                           end
                       end
                   end
                2: if (ss) m_mode = 1;
                default: if (ss) model_idle();
                   else if (t) begin
                       m_aticks++;
                       if (m_aticks == ALARM_SECS * TPS) model_idle();
                   end
            endcase
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_model();
        check("model_min",     32'(cif.minutes),     m_min);
        check("model_sec",     32'(cif.seconds),     m_sec);
        check("model_state",   32'(cif.state),       m_mode);
        check("model_alarm",   32'(cif.alarm),       m_alarm);
        check("model_restart", 32'(cif.div_restart), m_restart);
    endtask

    // One clock: drive inputs, step DUT and model, optionally compare.
    task automatic cycle(input logic t, ss, cl, im, is, input bit cmp);
        cif.tick = t; cif.start_stop = ss; cif.clear = cl;
        cif.inc_min = im; cif.inc_sec = is;
        @(posedge clk);
        #1;
        model_step(t, ss, cl, im, is);
        if (cmp) check_model();
        cif.tick = 0; cif.start_stop = 0; cif.clear = 0;
        cif.inc_min = 0; cif.inc_sec = 0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) cycle(1, 0, 0, 0, 0, 1);
    endtask

    typedef struct {
        logic       t, ss, cl, im, is;
        logic [6:0] emin;
        logic [5:0] esec;
        logic [1:0] est;
        logic       eal, ers;
    } vec_t;

    vec_t vecs [15];

    initial begin
        vecs[0]  = '{0,0,0,0,1, 7'd0, 6'd1, 2'b00, 0, 0};
        vecs[1]  = '{0,0,0,0,1, 7'd0, 6'd2, 2'b00, 0, 0};
        vecs[2]  = '{0,0,0,0,1, 7'd0, 6'd3, 2'b00, 0, 0};
        vecs[3]  = '{0,0,0,1,0, 7'd1, 6'd3, 2'b00, 0, 0};
        vecs[4]  = '{0,1,0,0,0, 7'd1, 6'd3, 2'b01, 0, 1};
        vecs[5]  = '{0,0,0,0,0, 7'd1, 6'd3, 2'b01, 0, 0};
        vecs[6]  = '{1,0,0,0,0, 7'd1, 6'd3, 2'b01, 0, 0};
        vecs[7]  = '{1,0,0,0,0, 7'd1, 6'd2, 2'b01, 0, 0};
        vecs[8]  = '{0,1,0,0,0, 7'd1, 6'd2, 2'b10, 0, 0};
        vecs[9]  = '{1,0,0,1,0, 7'd1, 6'd2, 2'b10, 0, 0};
        vecs[10] = '{0,1,0,0,0, 7'd1, 6'd2, 2'b01, 0, 0};
        vecs[11] = '{1,0,0,0,0, 7'd1, 6'd2, 2'b01, 0, 0};
        vecs[12] = '{1,0,0,0,0, 7'd1, 6'd1, 2'b01, 0, 0};
        vecs[13] = '{1,0,1,0,0, 7'd0, 6'd0, 2'b00, 0, 0};
        vecs[14] = '{0,1,0,0,0, 7'd0, 6'd0, 2'b00, 0, 0};

        cif.tick = 0; cif.start_stop = 0; cif.clear = 0;
        cif.inc_min = 0; cif.inc_sec = 0;
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        check("reset_state", 32'(cif.state), 0);
        check("reset_time",  32'({cif.minutes, cif.seconds}), 0);
        check("reset_flags", 32'({cif.alarm, cif.div_restart}), 0);
        reset = 1'b0;

        // Directed table
        foreach (vecs[i]) begin
            cycle(vecs[i].t, vecs[i].ss, vecs[i].cl, vecs[i].im, vecs[i].is, 0);
            check($sformatf("vec%0d_min", i),   32'(cif.minutes),     32'(vecs[i].emin));
            check($sformatf("vec%0d_sec", i),   32'(cif.seconds),     32'(vecs[i].esec));
            check($sformatf("vec%0d_state", i), 32'(cif.state),       32'(vecs[i].est));
            check($sformatf("vec%0d_alarm", i), 32'(cif.alarm),       32'(vecs[i].eal));
            check($sformatf("vec%0d_rst", i),   32'(cif.div_restart), 32'(vecs[i].ers));
        end

        // 01:00 rolls to 00:59, partial second does not decrement
        cycle(0, 0, 1, 0, 0, 1);
        cycle(0, 0, 0, 1, 0, 1);
        cycle(0, 1, 0, 0, 0, 1);
        ticks(2);
        check("roll_time", 32'({cif.minutes, cif.seconds}), {7'd0, 6'd59});
        ticks(1);
        check("partial_time", 32'({cif.minutes, cif.seconds}), {7'd0, 6'd59});
        ticks(1);
        check("next_time", 32'({cif.minutes, cif.seconds}), {7'd0, 6'd58});

        // 00:02 to alarm, then alarm timeout
        cycle(0, 0, 1, 0, 0, 1);
        cycle(0, 0, 0, 0, 1, 1);
        cycle(0, 0, 0, 0, 1, 1);
        cycle(0, 1, 0, 0, 0, 1);
        ticks(3);
        check("pre_alarm_state", 32'(cif.state), 1);
        ticks(1);
        check("alarm_state", 32'(cif.state), 3);
        check("alarm_flag",  32'(cif.alarm), 1);
        check("alarm_time",  32'({cif.minutes, cif.seconds}), 0);
        ticks(5);
        check("alarm_hold", 32'(cif.state), 3);
        ticks(1);
        check("timeout_state", 32'(cif.state), 0);
        check("timeout_flag",  32'(cif.alarm), 0);
        check("timeout_sec",   32'(cif.seconds), RELOAD ? 2 : 0);

        // Pause freezes time; resume has no divider restart
        cycle(0, 0, 1, 0, 0, 1);
        for (int i = 0; i < 10; i++) cycle(0, 0, 0, 0, 1, 1);
        cycle(0, 1, 0, 0, 0, 1);
        cycle(0, 1, 0, 0, 0, 1);
        check("pause_state", 32'(cif.state), 2);
        ticks(4);
        cycle(1, 0, 0, 1, 0, 1);
        check("pause_time", 32'({cif.minutes, cif.seconds}), {7'd0, 6'd10});
        cycle(0, 1, 0, 0, 0, 1);
        check("resume_state",   32'(cif.state), 1);
        check("resume_restart", 32'(cif.div_restart), 0);

        // Alarm silenced by start_stop
        cycle(0, 0, 1, 0, 0, 1);
        cycle(0, 0, 0, 0, 1, 1);
        cycle(0, 0, 0, 0, 1, 1);
        cycle(0, 1, 0, 0, 0, 1);
        ticks(4);
        cycle(0, 1, 0, 0, 0, 1);
        check("silence_state", 32'(cif.state), 0);
        check("silence_alarm", 32'(cif.alarm), 0);
        check("silence_sec",   32'(cif.seconds), RELOAD ? 2 : 0);

        // Asynchronous reset mid-run
        cycle(0, 0, 0, 0, 1, 1);
        cycle(0, 1, 0, 0, 0, 1);
        ticks(1);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("async_state", 32'(cif.state), 0);
        check("async_time",  32'({cif.minutes, cif.seconds}), 0);
        check("async_flags", 32'({cif.alarm, cif.div_restart}), 0);
        #1 reset = 1'b0;
        model_reset();

        // Randomized traffic against the model
        for (int n = 0; n < 4000; n++) begin
            int  r;
            logic t, ss, cl, im, is;
            r  = int'($urandom_range(0, 99));
            cl = (r < 2);
            ss = (r >= 2 && r < 8);
            t  = (r >= 8 && r < 60);
            im = (r >= 60) && ($urandom_range(0, 15) == 0);
            is = (r >= 60) && ($urandom_range(0, 1) == 1);
            cycle(t, ss, cl, im, is, 1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/countdown_controller.md
Name: countdown_controller

Overview:
- Sequencing controller for the egg timer countdown; sits between the tick-pulse clock divider and the display/alarm logic.
- Holds the minutes/seconds setpoint and accepts debounced one-cycle button pulses.
- Consumes the divider's 1-clk tick, decrements the time while running and raises the alarm at 00:00.
- Drives a restart strobe back to the divider so the first counted second is full length.

Parameters:
- TICKS_PER_SEC, 2, divider ticks per counted second (≥1)
- MAX_MIN, 99, highest settable minute value
- ALARM_SECS, 10, seconds the alarm sounds before auto-silence (≥1)
- SUB_W, 4, width of tick sub-counter and alarm-second counter (must hold max(TICKS_PER_SEC-1, ALARM_SECS))

Ports:
- clk  input  1  system clock, all state on posedge
- reset  input  1  reset, asynchronous, active-high
- tick  input  1  one-clk pulse from clock divider
- start_stop  input  1  one-clk pulse: start / pause / resume / silence
- clear  input  1  one-clk pulse: abort to IDLE, time 00:00
- inc_min  input  1  one-clk pulse: minutes +1 (IDLE only)
- inc_sec  input  1  one-clk pulse: seconds +1 (IDLE only)
- minutes  output  7  current minutes, binary
- seconds  output  6  current seconds, binary 0..59
- state  output  2  00 IDLE, 01 RUN, 10 PAUSE, 11 ALARM
- alarm  output  1  high while in ALARM
- div_restart  output  1  one-clk pulse to reload the divider

Behaviour:
- All outputs registered. On reset, asynchronously: minutes=0, seconds=0, state=IDLE, alarm=0, div_restart=0, sub-counter=0.
- Input priority within one cycle: clear > start_stop > tick > inc_min/inc_sec.
- IDLE:
  - inc_min: minutes+1; MAX_MIN wraps to 0.
  - inc_sec: seconds+1; 59 wraps to 0, with no carry into minutes.
  - inc_min and inc_sec together: both apply.
  - start_stop with time≠00:00: next cycle state=RUN, sub=0, and div_restart=1 for exactly that cycle.
  - start_stop at 00:00: ignored.
  - tick: ignored.
- RUN:
  - On tick, sub+1.
  - On tick with sub==TICKS_PER_SEC-1: sub=0 and the time decrements. If seconds>0, seconds-1; otherwise seconds=59 and minutes-1.
  - If the decrement yields 00:00, the same edge sets state=ALARM and alarm=1.
  - start_stop: PAUSE, with sub held.
  - inc_*: ignored.
- PAUSE:
  - tick and inc_*: ignored; time and sub frozen.
  - start_stop: RUN, with no div_restart and sub preserved; the partial second continues.
- ALARM:
  - Time reads 00:00.
  - Counts seconds using the same sub-counter rule.
  - After ALARM_SECS counted seconds: IDLE, alarm=0.
  - start_stop: IDLE immediately, alarm=0 on the next edge.
- clear, in any state: next edge state=IDLE, time 00:00, sub=0, alarm=0. If clear arrives in the same cycle as start_stop or tick, clear wins.
- 00:01 running: after TICKS_PER_SEC ticks the block enters ALARM directly, with no 00:00 RUN cycle.
- reset mid-count: everything returns to reset values regardless of clk.

Optional Feature:
- Macro: COUNTDOWN_RELOAD_EN.
- Defined:
  - A preset register captures minutes/seconds on every IDLE→RUN transition.
  - ALARM→IDLE exits (timeout or start_stop) load the preset into minutes/seconds.
  - clear still zeroes time and also zeroes the preset.
  - The preset resets to 00:00.
- Not defined: no preset register, and every return to IDLE shows 00:00.

Test Plan (TICKS_PER_SEC=2, ALARM_SECS=3):
- reset; inc_sec ×3, inc_min ×1 → 01:03, state=00; start_stop → next cycle state=01, div_restart high exactly 1 clk.
- From 01:00 RUN, 2 ticks → 00:59; 1 tick → still 00:59 with sub=1.
- 00:02 RUN; 4 ticks → on the 4th tick's edge state=11, alarm=1, time 00:00; 6 further ticks → state=00, alarm=0.
- RUN at 00:10; start_stop → PAUSE; 5 ticks plus inc_min → time stays 00:10; start_stop → RUN, div_restart stays 0.
- clear and tick in the same cycle during RUN → IDLE at 00:00; start_stop at 00:00 → stays IDLE. Also assert reset mid-RUN between clk edges → outputs clear immediately.
- With COUNTDOWN_RELOAD_EN: set 00:02, run to ALARM, press start_stop → IDLE showing 00:02. Without the macro, the same sequence → 00:00.
